xor_result_checker: RTL

//   Response end of the POS_XOR test path. Accepts (A, B, OUT) sample triples from a stimulus

---
 rtl/xor_result_checker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/xor_result_checker.sv
// Response checker for the POS_XOR path: compares each (A, B, OUT) triple against A^B,
// keeps saturating pass/fail counts, a sticky error flag and the operands of the first failure.
module xor_result_checker #(
    parameter int WIDTH       = 16,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] OUT,
    input  logic             CLR,
    output logic [CNT_W-1:0] PASS_CNT,
    output logic [CNT_W-1:0] FAIL_CNT,
    output logic             ERR,
    output logic             HALTED,
    output logic [WIDTH-1:0] FAIL_A,
    output logic [WIDTH-1:0] FAIL_B,
    output logic [WIDTH-1:0] FAIL_OUT,
    output logic [WIDTH-1:0] FAIL_EXP
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_q;
    logic               accept;
    logic               vld_p1_q;
    logic               vld_p2_q;
    logic [WIDTH-1:0]   a_p1_q;
    logic [WIDTH-1:0]   b_p1_q;
    logic [WIDTH-1:0]   out_p1_q;
    logic [WIDTH-1:0]   a_p2_q;
    logic [WIDTH-1:0]   b_p2_q;
    logic [WIDTH-1:0]   out_p2_q;
    logic [WIDTH-1:0]   exp_p2_q;
    logic               match_p2_q;
    logic [CNT_W-1:0]   pass_q;
    logic [CNT_W-1:0]   fail_q;
    logic               err_q;
    logic [WIDTH-1:0]   fail_a_q;
    logic [WIDTH-1:0]   fail_b_q;
    logic [WIDTH-1:0]   fail_out_q;
    logic [WIDTH-1:0]   fail_exp_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // CLR blocks acceptance in its own cycle; ready never depends on IN_VALID.
    assign IN_READY = (state_q == ST_RUN) && !CLR;
    assign accept   = IN_VALID && IN_READY;

    // Stage boundary p1 -> p2: operand capture, then expected value and compare.
    always_ff @(posedge CLK) begin
        if (accept) begin
            a_p1_q   <= A;
            b_p1_q   <= B;
            out_p1_q <= OUT;
        end
        if (vld_p1_q) begin
            a_p2_q     <= a_p1_q;
            b_p2_q     <= b_p1_q;
            out_p2_q   <= out_p1_q;
            exp_p2_q   <= a_p1_q ^ b_p1_q;
            match_p2_q <= (out_p1_q == (a_p1_q ^ b_p1_q));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_RUN;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            err_q      <= 1'b0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_out_q <= '0;
            fail_exp_q <= '0;
        end else if (CLR) begin
            state_q    <= ST_RUN;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            err_q      <= 1'b0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_out_q <= '0;
            fail_exp_q <= '0;
        end else begin
            vld_p1_q <= accept;
            vld_p2_q <= vld_p1_q;
            // Result stage: samples already in flight drain even while halted.
            if (vld_p2_q) begin
                if (match_p2_q) begin
                    pass_q <= sat_inc(pass_q);
                end else begin
                    fail_q <= sat_inc(fail_q);
                    err_q  <= 1'b1;
                    if (!err_q) begin
                        fail_a_q   <= a_p2_q;
                        fail_b_q   <= b_p2_q;
                        fail_out_q <= out_p2_q;
                        fail_exp_q <= exp_p2_q;
                    end
                    if (STOP_ON_ERR)
                        state_q <= ST_HALT;
                end
            end
        end
    end

    assign PASS_CNT = pass_q;
    assign FAIL_CNT = fail_q;
    assign ERR      = err_q;
    assign HALTED   = (state_q == ST_HALT);
    assign FAIL_A   = fail_a_q;
    assign FAIL_B   = fail_b_q;
    assign FAIL_OUT = fail_out_q;
    assign FAIL_EXP = fail_exp_q;

endmodule
